ram_responder: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/ram_word_array.sv | 30 +++
 rtl/ram_responder.sv | 139 +++++++++++++
 tb/tb_ram_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word_t, the RAM handshake state ramstate_t,
// and the upper bound on RAM responder latency.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int RAM_LAT_MAX = 15;
endpackage

// File: rtl/ram_word_array.sv
// DEPTH x 32 word storage: synchronous write, registered read port,
// synchronous clear of every word and of the read register on RST.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side RAM endpoint answering ramREN/ramWEN after LAT cycles.
// Optional RAM_STATS_EN adds rd_count/wr_count completion counters.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int    LAT     = 2,
  parameter int    DEPTH   = 1024,
  parameter word_t ERRWORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
`ifdef RAM_STATS_EN
  ,
  output word_t     rd_count,
  output word_t     wr_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_FREE, S_BUSY, S_ACCESS, S_ERROR} fsm_t;

  fsm_t        state, state_n;
  logic [3:0]  cnt, cnt_n;
  word_t       addr_q, addr_n;
  logic        wen_q, wen_n;
  logic        ld_err;
  logic        go, err, start;
  logic        req_valid, bad;
  word_t       rdata;

  assign req_valid = ramREN ^ ramWEN;
  assign bad = (ramREN & ramWEN) |
               ((ramREN | ramWEN) & ((ramaddr[1:0] != 2'b00) ||
                                     (ramaddr >= 32'(4 * DEPTH))));

  // Any state other than BUSY (or a BUSY abort) treats the inputs as a fresh request.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    wen_n   = wen_q;
    go      = 1'b0;
    err     = 1'b0;
    start   = 1'b0;
    if (state == S_BUSY) begin
      if (req_valid && (ramaddr == addr_q) && (ramWEN == wen_q)) begin
        if (cnt == 4'd1) begin
          state_n = S_ACCESS;
          go      = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end else begin
        start = 1'b1;
      end
    end else begin
      start = 1'b1;
    end
    if (start) begin
      if (bad) begin
        state_n = S_ERROR;
        err     = 1'b1;
      end else if (req_valid) begin
        addr_n = ramaddr;
        wen_n  = ramWEN;
        if (LAT == 1) begin
          state_n = S_ACCESS;
          go      = 1'b1;
        end else begin
          state_n = S_BUSY;
          cnt_n   = 4'(LAT - 1);
        end
      end else begin
        state_n = S_FREE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_FREE;
      cnt    <= '0;
      addr_q <= '0;
      wen_q  <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      wen_q  <= wen_n;
      if (err)
        ld_err <= 1'b1;
      else if (go && !ramWEN)
        ld_err <= 1'b0;
    end
  end

`ifdef RAM_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (go) begin
      if (ramWEN) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
    end
  end
`endif

  ram_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .CLK   (CLK),
    .RST   (RST),
    .we    (go & ramWEN),
    .re    (go & ~ramWEN),
    .addr  (ramaddr[AW+1:2]),
    .wdata (ramstore),
    .rdata (rdata)
  );

  // ramload holds the last read word unless the most recent event was an ERROR.
  assign ramload = ld_err ? ERRWORD : rdata;

  always_comb begin
    case (state)
      S_BUSY:   ramstate = BUSY;
      S_ACCESS: ramstate = ACCESS;
      S_ERROR:  ramstate = ERROR;
      default:  ramstate = FREE;
    endcase
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT=1, 2 and 4; stats checked with RAM_STATS_EN.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  ramREN = 1'b0, ramWEN = 1'b0;
  word_t ramaddr = '0, ramstore = '0;

  word_t ld1, ld2, ld4;
  ramstate_t st1, st2, st4;
`ifdef RAM_STATS_EN
  word_t rc1, wc1, rc2, wc2, rc4, wc4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(1)) u1 (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ld1), .ramstate(st1)
`ifdef RAM_STATS_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );
  ram_responder #(.LAT(2)) u2 (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ld2), .ramstate(st2)
`ifdef RAM_STATS_EN
    , .rd_count(rc2), .wr_count(wc2)
`endif
  );
  ram_responder #(.LAT(4)) u4 (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ld4), .ramstate(st4)
`ifdef RAM_STATS_EN
    , .rd_count(rc4), .wr_count(wc4)
`endif
  );

  typedef struct {
    logic      ren;
    logic      wen;
    word_t     addr;
    word_t     store;
    ramstate_t st;
    word_t     ld;
  } vec_t;

  vec_t tv[27];

  task automatic setv(input int i, input logic r, input logic w, input word_t a,
                      input word_t d, input ramstate_t s, input word_t l);
    tv[i].ren = r; tv[i].wen = w; tv[i].addr = a; tv[i].store = d;
    tv[i].st = s; tv[i].ld = l;
  endtask

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input word_t a, input word_t d);
    ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // LAT=2 table: write/read, ERROR cases, last word, latest store data wins.
    setv(0,  0,0,32'h0,   32'h0,        FREE,  32'h0);
    setv(1,  0,1,32'h40,  32'hDEADBEEF, BUSY,  32'h0);
    setv(2,  0,1,32'h40,  32'hDEADBEEF, ACCESS,32'h0);
    setv(3,  1,0,32'h40,  32'h0,        BUSY,  32'h0);
    setv(4,  1,0,32'h40,  32'h0,        ACCESS,32'hDEADBEEF);
    setv(5,  0,0,32'h0,   32'h0,        FREE,  32'hDEADBEEF);
    setv(6,  1,1,32'h10,  32'h55,       ERROR, 32'hBAD1BAD1);
    setv(7,  0,0,32'h0,   32'h0,        FREE,  32'hBAD1BAD1);
    setv(8,  1,0,32'h1002,32'h0,        ERROR, 32'hBAD1BAD1);
    setv(9,  0,0,32'h0,   32'h0,        FREE,  32'hBAD1BAD1);
    setv(10, 0,1,32'd4096,32'h1,        ERROR, 32'hBAD1BAD1);
    setv(11, 0,0,32'h0,   32'h0,        FREE,  32'hBAD1BAD1);
    setv(12, 1,0,32'h40,  32'h0,        BUSY,  32'hBAD1BAD1);
    setv(13, 1,0,32'h40,  32'h0,        ACCESS,32'hDEADBEEF);
    setv(14, 1,0,32'h10,  32'h0,        BUSY,  32'hDEADBEEF);
    setv(15, 1,0,32'h10,  32'h0,        ACCESS,32'h0);
    setv(16, 0,0,32'h0,   32'h0,        FREE,  32'h0);
    setv(17, 0,1,32'hFFC, 32'h12345678, BUSY,  32'h0);
    setv(18, 0,1,32'hFFC, 32'h12345678, ACCESS,32'h0);
    setv(19, 1,0,32'hFFC, 32'h0,        BUSY,  32'h0);
    setv(20, 1,0,32'hFFC, 32'h0,        ACCESS,32'h12345678);
    setv(21, 0,0,32'h0,   32'h0,        FREE,  32'h12345678);
    setv(22, 0,1,32'h44,  32'h1,        BUSY,  32'h12345678);
    setv(23, 0,1,32'h44,  32'h2,        ACCESS,32'h12345678);
    setv(24, 1,0,32'h44,  32'h0,        BUSY,  32'h12345678);
    setv(25, 1,0,32'h44,  32'h0,        ACCESS,32'h2);
    setv(26, 0,0,32'h0,   32'h0,        FREE,  32'h2);

    // Reset then idle for 10 cycles on all three instances.
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d_st2", i), 32'(st2), 32'(FREE));
      chk($sformatf("idle%0d_ld2", i), ld2, 32'h0);
      chk($sformatf("idle%0d_st1", i), 32'(st1), 32'(FREE));
      chk($sformatf("idle%0d_st4", i), 32'(st4), 32'(FREE));
      chk($sformatf("idle%0d_ld4", i), ld4, 32'h0);
    end
`ifdef RAM_STATS_EN
    chk("idle_rd_count", rc2, 32'd0);
    chk("idle_wr_count", wc2, 32'd0);
`endif

    for (int i = 0; i < 27; i++) begin
      drive(tv[i].ren, tv[i].wen, tv[i].addr, tv[i].store);
      step();
      chk($sformatf("tbl%0d_state", i), 32'(st2), 32'(tv[i].st));
      chk($sformatf("tbl%0d_load", i), ld2, tv[i].ld);
    end
`ifdef RAM_STATS_EN
    chk("tbl_rd_count", rc2, 32'd5);
    chk("tbl_wr_count", wc2, 32'd3);
`endif

    // LAT=4: preload 0x80, aborted read, then a full re-issued read.
    do_reset();
    drive(0, 1, 32'h80, 32'hCAFEF00D);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("l4_wr%0d_st", k), 32'(st4), 32'(k == 4 ? ACCESS : BUSY));
    end
    drive(0, 0, 0, 0);
    step();
    drive(1, 0, 32'h80, 0);
    step();
    chk("l4_abort_busy1", 32'(st4), 32'(BUSY));
    step();
    chk("l4_abort_busy2", 32'(st4), 32'(BUSY));
    drive(0, 0, 0, 0);
    step();
    chk("l4_abort_free", 32'(st4), 32'(FREE));
    chk("l4_abort_load", ld4, 32'h0);
    drive(1, 0, 32'h80, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("l4_rd%0d_st", k), 32'(st4), 32'(k == 4 ? ACCESS : BUSY));
    end
    chk("l4_rd_load", ld4, 32'hCAFEF00D);
    drive(0, 0, 0, 0);
    step();
    chk("l4_rd_free", 32'(st4), 32'(FREE));
`ifdef RAM_STATS_EN
    chk("l4_rd_count", rc4, 32'd1);
    chk("l4_wr_count", wc4, 32'd1);
`endif

    // LAT=1: back-to-back writes then reads, ACCESS every cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'(4 * k), 32'h11111111 * (k + 1));
      step();
      chk($sformatf("l1_wr%0d_st", k), 32'(st1), 32'(ACCESS));
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'(4 * k), 0);
      step();
      chk($sformatf("l1_rd%0d_st", k), 32'(st1), 32'(ACCESS));
      chk($sformatf("l1_rd%0d_ld", k), ld1, 32'h11111111 * (k + 1));
    end
    step();
    chk("l1_repeat_st", 32'(st1), 32'(ACCESS));
    drive(0, 0, 0, 0);
    step();
    chk("l1_free_st", 32'(st1), 32'(FREE));
    chk("l1_hold_ld", ld1, 32'h33333333);
`ifdef RAM_STATS_EN
    chk("l1_rd_count", rc1, 32'd4);
    chk("l1_wr_count", wc1, 32'd3);
`endif

    // Reset during BUSY of a write aborts it.
    do_reset();
    drive(0, 1, 32'h20, 32'hAAAA5555);
    step();
    chk("rst_busy_st", 32'(st2), 32'(BUSY));
    RST = 1'b1;
    step();
    chk("rst_free_st", 32'(st2), 32'(FREE));
    RST = 1'b0;
    drive(0, 0, 0, 0);
    step();
    drive(1, 0, 32'h20, 0);
    step();
    chk("rst_rd_busy", 32'(st2), 32'(BUSY));
    step();
    chk("rst_rd_access", 32'(st2), 32'(ACCESS));
    chk("rst_rd_load", ld2, 32'h0);
`ifdef RAM_STATS_EN
    chk("rst_wr_count", wc2, 32'd0);
`endif
    drive(0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
